// File: rtl/logic_gate_unit_pkg.sv
// Shared op encodings, FSM state type and the op-to-combiner mapping used by
// the logic_gate_unit datapath.
package logic_gate_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    CMB_AND,
    CMB_OR,
    CMB_XOR,
    CMB_REPL
  } cmb_t;

  // Inverting ops fold with their non-inverted base so a burst of NANDs is an
  // AND of the per-beat NAND results.
  function automatic cmb_t combiner_of(input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: combiner_of = CMB_AND;
      OP_OR,  OP_NOR:  combiner_of = CMB_OR;
      OP_XOR, OP_XNOR: combiner_of = CMB_XOR;
      default:         combiner_of = CMB_REPL;
    endcase
  endfunction

endpackage

// File: rtl/logic_gate_unit_if.sv
// Operand/result handshake bundle for logic_gate_unit. O_PAR exists only when
// LOGIC_GATE_UNIT_PARITY_EN is defined.
interface logic_gate_unit_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic             I_VALID;
  logic             I_READY;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [2:0]       OP;
  logic             ACC;
  logic             LAST;
  logic             O_VALID;
  logic             O_READY;
  logic [WIDTH-1:0] O;
  logic [CW-1:0]    BEATS;
  logic             OVF;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic             O_PAR;
`endif

  modport master (
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    input  O_PAR,
`endif
    output I_VALID, I1, I2, OP, ACC, LAST, O_READY,
    input  I_READY, O_VALID, O, BEATS, OVF
  );

  modport slave (
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    output O_PAR,
`endif
    input  I_VALID, I1, I2, OP, ACC, LAST, O_READY,
    output I_READY, O_VALID, O, BEATS, OVF
  );

endinterface

// File: rtl/logic_gate_alu.sv
// Combinational bitwise op stage: r = f_op(i1, i2).
module logic_gate_alu
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r
);

  // NOTE: a default assignment ahead of the case keeps this block purely
  // combinational even if an arm is later removed; no latch can be inferred.
  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = i1 & i2;
      OP_OR:   r = i1 | i2;
      OP_XOR:  r = i1 ^ i2;
      OP_NAND: r = ~(i1 & i2);
      OP_NOR:  r = ~(i1 | i2);
      OP_XNOR: r = ~(i1 ^ i2);
      OP_NOT:  r = ~i1;
      default: r = i1;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered N-bit logic unit with single-op and burst-accumulate modes.
// Optional O_PAR output enabled by LOGIC_GATE_UNIT_PARITY_EN.
module logic_gate_unit
  import logic_gate_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic          CLK,
  input  logic          RST,
  logic_gate_unit_if.slave bus
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] o_q;
  logic [CW-1:0]    beats_q;
  logic             ovf_q;
  logic             o_valid_q;

  logic             i_ready;
  logic             beat;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] acc_new;
  logic [CW-1:0]    cnt_new;
  logic             term;
  logic             load_o;
  logic [WIDTH-1:0] o_d;
  logic [CW-1:0]    beats_d;
  logic             ovf_d;

  assign beat    = bus.I_VALID && i_ready;
  assign op_eff  = (state_q == ACCUM) ? op_q : bus.OP;
  assign cnt_new = cnt_q + CW'(1);
  assign term    = bus.LAST || (cnt_new == CW'(MAX_BEATS));

  logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
    .i1 (bus.I1),
    .i2 (bus.I2),
    .op (op_eff),
    .r  (r)
  );

  always_comb begin
    acc_new = r;
    case (combiner_of(op_q))
      CMB_AND: acc_new = acc_q & r;
      CMB_OR:  acc_new = acc_q | r;
      CMB_XOR: acc_new = acc_q ^ r;
      default: acc_new = r;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A draining HOLD behaves like IDLE for the incoming beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: begin
        if (state_q == IDLE || bus.O_READY) begin
          if (beat) state_d = (!bus.ACC || bus.LAST) ? HOLD : ACCUM;
          else      state_d = IDLE;
        end
      end
      ACCUM:   if (beat && term) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the only combinational output.
  always_comb begin
    i_ready = !RST && ((state_q != HOLD) || bus.O_READY);
  end

  // Result-register load decision.
  always_comb begin
    load_o  = 1'b0;
    o_d     = r;
    beats_d = CW'(1);
    ovf_d   = 1'b0;
    if (beat) begin
      if (state_q == ACCUM) begin
        load_o  = term;
        o_d     = acc_new;
        beats_d = cnt_new;
        ovf_d   = !bus.LAST;
      end else begin
        load_o  = !bus.ACC || bus.LAST;
      end
    end
  end

  // NOTE: the accumulator and counter are plain flops, not a memory array, so
  // clearing them on reset is cheap and guarantees a discarded burst leaves
  // nothing behind.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q      <= OP_AND;
      acc_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      beats_q   <= '0;
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      o_valid_q <= (state_d == HOLD);
      if (beat) begin
        if (state_q == ACCUM) begin
          acc_q <= acc_new;
          cnt_q <= cnt_new;
        end else if (bus.ACC) begin
          op_q  <= bus.OP;
          acc_q <= r;
          cnt_q <= CW'(1);
        end
      end
      if (load_o) begin
        o_q     <= o_d;
        beats_q <= beats_d;
        ovf_q   <= ovf_d;
      end
    end
  end

`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic o_par_q;
  always_ff @(posedge CLK) begin
    if (RST)         o_par_q <= 1'b0;
    else if (load_o) o_par_q <= ^o_d;
  end
  assign bus.O_PAR = o_par_q;
`endif

  assign bus.I_READY = i_ready;
  assign bus.O_VALID = o_valid_q;
  assign bus.O       = o_q;
  assign bus.BEATS   = beats_q;
  assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit (WIDTH=8, MAX_BEATS=16).
module tb_logic_gate_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  logic_gate_unit_if #(.WIDTH(8), .MAX_BEATS(16)) bus ();

  logic_gate_unit #(.WIDTH(8), .MAX_BEATS(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // {O_VALID, O, BEATS, OVF}
  logic [14:0] got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic acc, input logic last);
    bus.I1 = a; bus.I2 = b; bus.OP = op; bus.ACC = acc; bus.LAST = last;
    bus.I_VALID = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== 15'h0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h want %h", got, 15'h0);
    end
    tests_run++;
    if (bus.I_READY !== 1'b0) begin
      tests_failed++; $display("FAIL reset_i_ready: got %b want 0", bus.I_READY);
    end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    tests_run++;
    if (bus.O_PAR !== 1'b0) begin
      tests_failed++; $display("FAIL reset_o_par: got %b want 0", bus.O_PAR);
    end
`endif
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.I_READY !== 1'b1) begin
      tests_failed++; $display("FAIL idle_i_ready: got %b want 1", bus.I_READY);
    end
  endtask

  task automatic test_single_or();
    bus.O_READY = 1'b1;
    drive(8'hA0, 8'h0F, 3'b001, 1'b0, 1'b0);
    tick();
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'hAF, 5'd1, 1'b0}) begin
      tests_failed++; $display("FAIL single_or: got %h want %h", got, {1'b1, 8'hAF, 5'd1, 1'b0});
    end
    tick();
    tests_run++;
    if (bus.O_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL single_or_drain: got %b want 0", bus.O_VALID);
    end
  endtask

  task automatic test_back_to_back();
    bus.O_READY = 1'b1;
    drive(8'hFF, 8'h0F, 3'b011, 1'b0, 1'b0);
    tick();
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'hF0, 5'd1, 1'b0}) begin
      tests_failed++; $display("FAIL b2b_nand: got %h want %h", got, {1'b1, 8'hF0, 5'd1, 1'b0});
    end
    drive(8'h3C, 8'h00, 3'b110, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (bus.I_READY !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_i_ready: got %b want 1", bus.I_READY);
    end
    tick();
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'hC3, 5'd1, 1'b0}) begin
      tests_failed++; $display("FAIL b2b_not: got %h want %h", got, {1'b1, 8'hC3, 5'd1, 1'b0});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.O_READY = 1'b0;
    drive(8'h55, 8'hFF, 3'b010, 1'b0, 1'b0);
    tick();
    // Offer a competing beat while stalled; it must not be taken.
    drive(8'h00, 8'h00, 3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
      tests_run++;
      if (got !== {1'b1, 8'hAA, 5'd1, 1'b0} || bus.I_READY !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got %h ready %b want %h ready 0", i, got, bus.I_READY,
                 {1'b1, 8'hAA, 5'd1, 1'b0});
      end
      tick();
    end
    bus.I_VALID = 1'b0;
    bus.O_READY = 1'b1;
    #1;
    tests_run++;
    if (bus.I_READY !== 1'b1 || bus.O !== 8'hAA) begin
      tests_failed++; $display("FAIL bp_release: ready %b o %h want 1 aa", bus.I_READY, bus.O);
    end
    tick();
    tests_run++;
    if (bus.O_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drained: got %b want 0", bus.O_VALID);
    end
  endtask

  task automatic test_accum_xor();
    bus.O_READY = 1'b1;
    drive(8'h01, 8'h00, 3'b010, 1'b1, 1'b0);
    tick();
    // OP/ACC on later beats are ignored; op_q (XOR) governs.
    drive(8'h02, 8'h00, 3'b000, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.O_VALID !== 1'b0) begin
      tests_failed++; $display("FAIL accum_mid_valid: got %b want 0", bus.O_VALID);
    end
    drive(8'h04, 8'h00, 3'b111, 1'b0, 1'b1);
    tick();
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'h07, 5'd3, 1'b0}) begin
      tests_failed++; $display("FAIL accum_xor: got %h want %h", got, {1'b1, 8'h07, 5'd3, 1'b0});
    end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    tests_run++;
    if (bus.O_PAR !== 1'b1) begin
      tests_failed++; $display("FAIL accum_o_par: got %b want 1", bus.O_PAR);
    end
`endif
    tick();
  endtask

  task automatic test_overflow();
    bus.O_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive((i == 5) ? 8'h7F : 8'hFF, 8'hFF, 3'b000, 1'b1, 1'b0);
      tick();
      if (i == 15) begin
        tests_run++;
        if (bus.O_VALID !== 1'b0) begin
          tests_failed++; $display("FAIL ovf_beat15_valid: got %b want 0", bus.O_VALID);
        end
      end
    end
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'h7F, 5'd16, 1'b1}) begin
      tests_failed++; $display("FAIL overflow: got %h want %h", got, {1'b1, 8'h7F, 5'd16, 1'b1});
    end
    tick();
  endtask

  task automatic test_last_at_max();
    bus.O_READY = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) drive(8'h80, 8'h01, 3'b001, 1'b1, 1'b1);
      else         drive(8'h00, 8'h00, 3'b001, 1'b1, 1'b0);
      tick();
    end
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'h81, 5'd16, 1'b0}) begin
      tests_failed++; $display("FAIL last_at_max: got %h want %h", got, {1'b1, 8'h81, 5'd16, 1'b0});
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.O_READY = 1'b1;
    drive(8'h01, 8'h00, 3'b001, 1'b1, 1'b0);
    tick();
    drive(8'h02, 8'h00, 3'b001, 1'b0, 1'b0);
    tick();
    bus.I_VALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== 15'h0) begin
      tests_failed++; $display("FAIL mid_burst_reset: got %h want %h", got, 15'h0);
    end
    drive(8'h01, 8'h02, 3'b001, 1'b0, 1'b0);
    tick();
    bus.I_VALID = 1'b0;
    got = {bus.O_VALID, bus.O, bus.BEATS, bus.OVF};
    tests_run++;
    if (got !== {1'b1, 8'h03, 5'd1, 1'b0}) begin
      tests_failed++; $display("FAIL post_reset_or: got %h want %h", got, {1'b1, 8'h03, 5'd1, 1'b0});
    end
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    tests_run++;
    if (bus.O_PAR !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_o_par: got %b want 0", bus.O_PAR);
    end
`endif
    tick();
  endtask

  initial begin
    bus.I_VALID = 1'b0; bus.I1 = '0; bus.I2 = '0; bus.OP = '0;
    bus.ACC = 1'b0; bus.LAST = 1'b0; bus.O_READY = 1'b0;
    test_reset();
    test_single_or();
    test_back_to_back();
    test_backpressure();
    test_accum_xor();
    test_overflow();
    test_last_at_max();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
